motor_ramp_sequencer: RTL and testbench
=======================================

Name: motor_ramp_sequencer

Overview:
Sequences the motor PWM datapath from the decoded HMI button pulses (start, stop, increase, decrease). Holds a user speed setpoint and drives the PWM duty command as a rate-limited ramp: soft start, slewed speed changes and soft stop. Sits between the button controller and the pwm generator. Also supplies the motor_running status to the HMI.

Parameters:
DUTY_W, 8, width of duty and setpoint.
STEP, 16, setpoint change per increase/decrease pulse.
MIN_DUTY, 32, setpoint floor and reset value of the setpoint. Legal range 1..2^DUTY_W-1.
RAMP_DIV, 50000, clocks per 1-LSB duty change. Must be >= 2.

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
btn_start  in  1  single-cycle pulse, request motor start
btn_stop  in  1  single-cycle pulse, request motor stop
btn_increase  in  1  single-cycle pulse, raise setpoint
btn_decrease  in  1  single-cycle pulse, lower setpoint
duty  out  DUTY_W  duty command to the pwm generator
pwm_en  out  1  PWM output enable
motor_running  out  1  high in every state except IDLE
setpoint  out  DUTY_W  current target duty
state  out  2  state code: IDLE=0, RAMP_UP=1, RUN=2, RAMP_DOWN=3

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- All outputs are registered. Inputs are sampled on the rising edge of clk.
- Reset values, applied on the edge where rst=1 and overriding all inputs:
  - state=IDLE, duty=0, pwm_en=0, motor_running=0.
  - setpoint=MIN_DUTY; ramp counter=0.
- Reset mid-operation: outputs take their reset values on the next edge. No ramp-down is performed.
- Setpoint, updated in every state:
  - btn_increase: setpoint = min(setpoint+STEP, 2^DUTY_W-1). Compute in DUTY_W+1 bits to avoid wrap.
  - btn_decrease: setpoint = max(setpoint-STEP, MIN_DUTY). Must not underflow.
  - btn_increase and btn_decrease in the same cycle: setpoint unchanged.
- Ramp counter and tick:
  - Counter is held at 0 in IDLE.
  - Counter clears to 0 on the edge that changes state.
  - Otherwise it increments each cycle and wraps from RAMP_DIV-1 to 0.
  - tick = (counter == RAMP_DIV-1).
- Command priority in the same cycle: btn_stop > btn_start.
- pwm_en and motor_running are both (state != IDLE), registered together with state.
- IDLE:
  - duty=0.
  - btn_start with no btn_stop: go to RAMP_UP.
  - btn_stop is ignored.
- RAMP_UP:
  - On tick: duty+1 if duty<setpoint; duty-1 if duty>setpoint.
  - When duty==setpoint: go to RUN on the next edge.
  - btn_stop: go to RAMP_DOWN.
  - btn_start is ignored.
- RUN:
  - On tick, duty tracks setpoint by 1 LSB (same rule as RAMP_UP); state stays RUN.
  - btn_stop: go to RAMP_DOWN.
  - btn_start is ignored.
- RAMP_DOWN:
  - On tick, duty-1.
  - duty==0: go to IDLE. pwm_en falls on the same edge as state.
  - btn_start with no btn_stop: go to RAMP_UP; the ramp resumes from the current duty, with no jump.
  - btn_stop is ignored.
- duty never exceeds 2^DUTY_W-1 and never goes below 0. It changes by at most 1 per tick.
- Latency:
  - btn_start at edge N gives state=RAMP_UP and pwm_en=1 after edge N.
  - The first duty increment is visible RAMP_DIV cycles after entering RAMP_UP.
  - Full ramp from 0 to setpoint S takes S*RAMP_DIV cycles, then 1 cycle to enter RUN.

Test Plan:
All scenarios use DUTY_W=8, STEP=16, MIN_DUTY=32, RAMP_DIV=4.
1. Reset: assert rst 2 cycles, including a simultaneous btn_start -> state=0, duty=0, pwm_en=0, motor_running=0, setpoint=32.
2. Soft start: btn_start pulse in IDLE ->
   - state=1 and pwm_en=1 next cycle;
   - duty=1 four cycles later;
   - duty=32 after 128 cycles;
   - state=2 on the following cycle.
3. Setpoint limits in RUN at duty 32:
   - 2x btn_increase -> setpoint=64; duty slews to 64 in 128 cycles, state stays 2.
   - 20x btn_increase -> setpoint=255.
   - 20x btn_decrease -> setpoint=32.
   - increase and decrease in the same cycle -> setpoint unchanged.
4. Soft stop: btn_stop during RAMP_UP at duty=10 -> state=3 next cycle; duty=0 after 40 cycles; then state=0, pwm_en=0, motor_running=0.
5. Simultaneous and restart:
   - btn_start+btn_stop together in IDLE -> stays IDLE.
   - btn_start in RAMP_DOWN at duty=20 -> state=1, duty rises 20 -> 21 four cycles later.
   - btn_start in RUN -> ignored.
6. Reset mid-RUN at duty=64, setpoint=64 -> after the next edge duty=0, state=0, setpoint=32, pwm_en=0.

Source files
------------

// File: rtl/motor_ramp_sequencer.sv
// Motor ramp sequencer: holds the user speed setpoint and slews the PWM duty
// command toward it one LSB per ramp tick (soft start, speed changes, soft stop).
module motor_ramp_sequencer #(
    parameter int DUTY_W   = 8,
    parameter int STEP     = 16,
    parameter int MIN_DUTY = 32,
    parameter int RAMP_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_start,
    input  logic              btn_stop,
    input  logic              btn_increase,
    input  logic              btn_decrease,
    output logic [DUTY_W-1:0] duty,
    output logic              pwm_en,
    output logic              motor_running,
    output logic [DUTY_W-1:0] setpoint,
    output logic [1:0]        state
);

    localparam int CNT_W = $clog2(RAMP_DIV);
    localparam int SP_W  = DUTY_W + 2;

    localparam logic [DUTY_W-1:0] DUTY_MAX  = '1;
    localparam logic [DUTY_W-1:0] DUTY_MIN  = DUTY_W'(MIN_DUTY);
    localparam logic [SP_W-1:0]   STEP_W    = SP_W'(STEP);
    localparam logic [SP_W-1:0]   MIN_W     = SP_W'(MIN_DUTY);
    localparam logic [SP_W-1:0]   MAX_W     = SP_W'(DUTY_MAX);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(RAMP_DIV - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RUN       = 2'd2,
        RAMP_DOWN = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [DUTY_W-1:0] setpoint_q, setpoint_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              run_q, run_d;

    logic              tick;
    logic [SP_W-1:0]   sp_wide;
    logic [SP_W-1:0]   sp_plus;
    logic [DUTY_W-1:0] sp_inc;
    logic [DUTY_W-1:0] sp_dec;
    logic [DUTY_W-1:0] duty_track;

    assign tick = (cnt_q == CNT_LAST);

    // Saturating setpoint arithmetic done in a wider word so neither edge wraps.
    assign sp_wide = {2'b00, setpoint_q};
    assign sp_plus = sp_wide + STEP_W;
    assign sp_inc  = (sp_plus > MAX_W) ? DUTY_MAX : sp_plus[DUTY_W-1:0];
    assign sp_dec  = (sp_wide < MIN_W + STEP_W) ? DUTY_MIN : setpoint_q - STEP_W[DUTY_W-1:0];

    assign duty_track = (duty_q < setpoint_q) ? duty_q + DUTY_W'(1) :
                        (duty_q > setpoint_q) ? duty_q - DUTY_W'(1) : duty_q;

    always_comb begin
        state_d    = state_q;
        duty_d     = duty_q;
        setpoint_d = setpoint_q;
        cnt_d      = cnt_q;
        run_d      = run_q;

        if (btn_increase && !btn_decrease) begin
            setpoint_d = sp_inc;
        end else if (btn_decrease && !btn_increase) begin
            setpoint_d = sp_dec;
        end

        case (state_q)
            IDLE: begin
                duty_d = '0;
                if (btn_start && !btn_stop) begin
                    state_d = RAMP_UP;
                end
            end
            RAMP_UP: begin
                if (btn_stop) begin
                    state_d = RAMP_DOWN;
                end else if (duty_q == setpoint_q) begin
                    state_d = RUN;
                end
                if (tick) begin
                    duty_d = duty_track;
                end
            end
            RUN: begin
                if (btn_stop) begin
                    state_d = RAMP_DOWN;
                end
                if (tick) begin
                    duty_d = duty_track;
                end
            end
            RAMP_DOWN: begin
                // A restart takes precedence over finishing the stop, so the
                // ramp resumes from wherever duty currently sits.
                if (btn_start && !btn_stop) begin
                    state_d = RAMP_UP;
                end else if (duty_q == '0) begin
                    state_d = IDLE;
                end
                if (tick && (duty_q != '0)) begin
                    duty_d = duty_q - DUTY_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                duty_d  = '0;
            end
        endcase

        if ((state_q == IDLE) || (state_d != state_q)) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        run_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            duty_q     <= '0;
            setpoint_q <= DUTY_MIN;
            cnt_q      <= '0;
            run_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            duty_q     <= duty_d;
            setpoint_q <= setpoint_d;
            cnt_q      <= cnt_d;
            run_q      <= run_d;
        end
    end

    assign duty          = duty_q;
    assign setpoint      = setpoint_q;
    assign state         = state_q;
    assign pwm_en        = run_q;
    assign motor_running = run_q;

endmodule

// File: tb/tb_motor_ramp_sequencer.sv
// Scoreboarded bench for motor_ramp_sequencer: directed scenarios then random
// button traffic, each cycle checked against a behavioural model.
module tb_motor_ramp_sequencer;

    localparam int DUTY_W   = 8;
    localparam int STEP     = 16;
    localparam int MIN_DUTY = 32;
    localparam int RAMP_DIV = 4;
    localparam int DMAX     = 255;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_stop = 1'b0;
    logic       btn_increase = 1'b0;
    logic       btn_decrease = 1'b0;
    logic [7:0] duty;
    logic       pwm_en;
    logic       motor_running;
    logic [7:0] setpoint;
    logic [1:0] state;

    always #5 clk = ~clk;

    motor_ramp_sequencer #(
        .DUTY_W  (DUTY_W),
        .STEP    (STEP),
        .MIN_DUTY(MIN_DUTY),
        .RAMP_DIV(RAMP_DIV)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_start    (btn_start),
        .btn_stop     (btn_stop),
        .btn_increase (btn_increase),
        .btn_decrease (btn_decrease),
        .duty         (duty),
        .pwm_en       (pwm_en),
        .motor_running(motor_running),
        .setpoint     (setpoint),
        .state        (state)
    );

    typedef struct {
        int st;
        int duty;
        int sp;
        int en;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;

    // Behavioural model: mode 0 idle, 1 ramping up, 2 running, 3 ramping down.
    int m_state = 0;
    int m_duty  = 0;
    int m_sp    = MIN_DUTY;
    int m_age   = 0;   // cycles spent in the current mode

    task automatic check(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit start, input bit stop,
                              input bit inc, input bit dec);
        int  ns;
        int  nd;
        int  nsp;
        bit  tick;
        exp_t e;
        if (r) begin
            m_state = 0;
            m_duty  = 0;
            m_sp    = MIN_DUTY;
            m_age   = 0;
        end else begin
            tick = (m_state != 0) && (((m_age + 1) % RAMP_DIV) == 0);
            nsp  = m_sp;
            if (inc && !dec) nsp = (m_sp + STEP > DMAX) ? DMAX : m_sp + STEP;
            if (dec && !inc) nsp = (m_sp - STEP < MIN_DUTY) ? MIN_DUTY : m_sp - STEP;
            ns = m_state;
            nd = m_duty;
            case (m_state)
                0: begin
                    nd = 0;
                    if (start && !stop) ns = 1;
                end
                1, 2: begin
                    if (stop) ns = 3;
                    else if (m_state == 1 && m_duty == m_sp) ns = 2;
                    if (tick && m_duty < m_sp) nd = m_duty + 1;
                    if (tick && m_duty > m_sp) nd = m_duty - 1;
                end
                default: begin
                    if (start && !stop) ns = 1;
                    else if (m_duty == 0) ns = 0;
                    if (tick && m_duty > 0) nd = m_duty - 1;
                end
            endcase
            m_age   = (ns == m_state && ns != 0) ? m_age + 1 : 0;
            m_state = ns;
            m_duty  = nd;
            m_sp    = nsp;
        end
        e.st   = m_state;
        e.duty = m_duty;
        e.sp   = m_sp;
        e.en   = (m_state != 0) ? 1 : 0;
        sb_q.push_back(e);
    endtask

    // One clock cycle: apply inputs, predict, advance to the following negedge.
    task automatic step(input bit r, input bit start, input bit stop,
                        input bit inc, input bit dec);
        rst          = r;
        btn_start    = start;
        btn_stop     = stop;
        btn_increase = inc;
        btn_decrease = dec;
        model_step(r, start, stop, inc, dec);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    // Advance until the model reaches the given mode (and duty, if d >= 0).
    task automatic wait_model(input string name, input int st, input int d);
        bit hit;
        hit = 0;
        for (int i = 0; i < 3000; i++) begin
            if (m_state == st && (d < 0 || m_duty == d)) begin
                hit = 1;
                break;
            end
            step(0, 0, 0, 0, 0);
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL %s: wait bound expired, state %0d duty %0d required %0d/%0d",
                     name, m_state, m_duty, st, d);
        end
    endtask

    // Monitor: every edge presents a new output set; pop and compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("sb_state", state, e.st);
                check("sb_duty", duty, e.duty);
                check("sb_setpoint", setpoint, e.sp);
                check("sb_pwm_en", pwm_en, e.en);
                check("sb_running", motor_running, e.en);
            end
        end
    end

    initial begin
        @(negedge clk);

        // Reset, with a start pulse that must be overridden
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        $display("reset: state=%0d duty=%0d sp=%0d en=%0d", state, duty, setpoint, pwm_en);
        check("rst_state", state, 0);
        check("rst_duty", duty, 0);
        check("rst_sp", setpoint, 32);
        check("rst_en", pwm_en, 0);
        check("rst_run", motor_running, 0);

        // Soft start
        step(0, 1, 0, 0, 0);
        check("start_state", state, 1);
        check("start_en", pwm_en, 1);
        idle(3);
        check("start_duty0", duty, 0);
        idle(1);
        check("start_duty1", duty, 1);
        idle(124);
        check("ramp_duty32", duty, 32);
        check("ramp_state", state, 1);
        idle(1);
        check("run_state", state, 2);
        $display("soft start: state=%0d duty=%0d", state, duty);

        // Setpoint limits in RUN
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        check("sp_64", setpoint, 64);
        idle(140);
        check("slew_duty64", duty, 64);
        check("slew_state", state, 2);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 0);
        check("sp_max", setpoint, 255);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 1);
        check("sp_min", setpoint, 32);
        step(0, 0, 0, 1, 1);
        check("sp_both", setpoint, 32);
        $display("setpoint limits: sp=%0d duty=%0d", setpoint, duty);
        step(0, 0, 1, 0, 0);
        wait_model("stop_to_idle", 0, -1);

        // Soft stop from RAMP_UP at duty 10
        step(0, 1, 0, 0, 0);
        wait_model("up_to_10", 1, 10);
        step(0, 0, 1, 0, 0);
        check("stop_state", state, 3);
        idle(39);
        check("stop_duty1", duty, 1);
        idle(1);
        check("stop_duty0", duty, 0);
        idle(1);
        check("stopped_state", state, 0);
        check("stopped_en", pwm_en, 0);
        check("stopped_run", motor_running, 0);
        $display("soft stop: state=%0d duty=%0d", state, duty);

        // Simultaneous start+stop, restart during ramp-down, start in RUN
        step(0, 1, 1, 0, 0);
        check("both_idle", state, 0);
        step(0, 1, 0, 0, 0);
        wait_model("up_to_25", 1, 25);
        step(0, 0, 1, 0, 0);
        wait_model("down_to_20", 3, 20);
        step(0, 1, 0, 0, 0);
        check("restart_state", state, 1);
        check("restart_duty", duty, 20);
        idle(3);
        check("restart_hold", duty, 20);
        idle(1);
        check("restart_duty21", duty, 21);
        wait_model("reach_run", 2, -1);
        step(0, 1, 0, 0, 0);
        check("start_in_run", state, 2);
        $display("restart: state=%0d duty=%0d", state, duty);

        // Reset mid-RUN
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        wait_model("run_at_64", 2, 64);
        step(1, 0, 0, 0, 0);
        check("midrst_duty", duty, 0);
        check("midrst_state", state, 0);
        check("midrst_sp", setpoint, 32);
        check("midrst_en", pwm_en, 0);
        $display("reset mid-run: state=%0d duty=%0d sp=%0d", state, duty, setpoint);

        // Random button traffic
        for (int i = 0; i < 4000; i++) begin
            bit r, s, p, u, d;
            r = ($urandom_range(0, 999) < 3);
            s = ($urandom_range(0, 999) < 35);
            p = ($urandom_range(0, 999) < 15);
            u = ($urandom_range(0, 999) < 60);
            d = ($urandom_range(0, 999) < 60);
            step(r, s, p, u, d);
        end
        $display("random: 4000 cycles, final state=%0d duty=%0d sp=%0d", state, duty, setpoint);

        idle(1);
        check("sb_drain", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
